// File: rtl/mem_access_sequencer.sv
// Multicycle load/store sequencer: one datapath request becomes one or two aligned
// ready/valid memory beats with byte enables, then a single-cycle response pulse.
module mem_access_sequencer #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter bit          ALLOW_SPLIT = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_misaligned,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned BE_W  = 2 * BYTES;
  localparam int unsigned WIN_W = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t              state;
  logic                q_write;
  logic [1:0]          q_size;
  logic                q_signed;
  logic [OFF_W-1:0]    q_off;
  logic [1:0]          q_rot;
  logic                q_mis;
  logic                q_split;
  logic [BYTES-1:0]    be1_q;
  logic [DATA_W-1:0]   wd1_q;
  logic [DATA_W-1:0]   beat0_q;

  logic [3:0]          req_mask;
  logic [2:0]          req_sb;
  logic [ADDR_W-1:0]   req_ea;
  logic [OFF_W-1:0]    req_off;
  logic [BE_W-1:0]     req_be_win;
  logic [WIN_W-1:0]    req_wd_win;
  logic                req_split;
  logic                req_mis;

  // Request decode: both beats' enables and lane data come from one 2-beat window
  always_comb begin
    req_mask = 4'b1111;
    req_sb   = 3'd4;
    case (req_size)
      2'b00:   begin req_mask = 4'b0001; req_sb = 3'd1; end
      2'b01:   begin req_mask = 4'b0011; req_sb = 3'd2; end
      default: begin req_mask = 4'b1111; req_sb = 3'd4; end
    endcase
    // Legacy mode never splits: the access is forced onto its natural alignment
    req_ea     = ALLOW_SPLIT ? req_addr : (req_addr & ~ADDR_W'(req_sb - 3'd1));
    req_off    = req_ea[OFF_W-1:0];
    req_be_win = BE_W'(req_mask) << req_off;
    req_wd_win = WIN_W'(req_wdata) << {req_off, 3'b000};
    req_split  = ALLOW_SPLIT && ((32'(req_off) + 32'(req_sb)) > BYTES);
    req_mis    = |(req_addr[1:0] & req_mask[2:1]);
  end

  logic [WIN_W-1:0] asm_win;
  logic [31:0]      asm_word;
  logic [31:0]      asm_rot;
  logic [31:0]      asm_data;

  // Load assembly from the beat(s) in flight, then legacy rotate and extension
  always_comb begin
    asm_win  = (state == BEAT1) ? {mem_rdata, beat0_q} : {DATA_W'(0), mem_rdata};
    asm_word = 32'(asm_win >> {q_off, 3'b000});
    asm_rot  = 32'({asm_word, asm_word} >> {q_rot, 3'b000});
    case (q_size)
      2'b00:   asm_data = {{24{q_signed & asm_rot[7]}}, asm_rot[7:0]};
      2'b01:   asm_data = {{16{q_signed & asm_rot[15]}}, asm_rot[15:0]};
      default: asm_data = asm_rot;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
      mem_valid       <= 1'b0;
      mem_write       <= 1'b0;
      mem_addr        <= '0;
      mem_be          <= '0;
      mem_wdata       <= '0;
      q_write         <= 1'b0;
      q_size          <= '0;
      q_signed        <= 1'b0;
      q_off           <= '0;
      q_rot           <= '0;
      q_mis           <= 1'b0;
      q_split         <= 1'b0;
      be1_q           <= '0;
      wd1_q           <= '0;
      beat0_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            q_write   <= req_write;
            q_size    <= req_size;
            q_signed  <= req_signed;
            q_off     <= req_off;
            q_rot     <= (!ALLOW_SPLIT && req_size[1]) ? req_addr[1:0] : 2'b00;
            q_mis     <= req_mis;
            q_split   <= req_split;
            be1_q     <= req_be_win[BE_W-1:BYTES];
            wd1_q     <= req_wd_win[WIN_W-1:DATA_W];
            req_ready <= 1'b0;
            mem_valid <= 1'b1;
            mem_write <= req_write;
            mem_addr  <= {req_ea[ADDR_W-1:OFF_W], OFF_W'(0)};
            mem_be    <= req_be_win[BYTES-1:0];
            mem_wdata <= req_wd_win[DATA_W-1:0];
            state     <= BEAT0;
          end
        end
        BEAT0, BEAT1: begin
          if (mem_ready) begin
            if (state == BEAT0 && q_split) begin
              beat0_q   <= mem_rdata;
              mem_addr  <= mem_addr + ADDR_W'(BYTES);
              mem_be    <= be1_q;
              mem_wdata <= wd1_q;
              state     <= BEAT1;
            end else begin
              mem_valid       <= 1'b0;
              mem_write       <= 1'b0;
              resp_valid      <= 1'b1;
              resp_rdata      <= q_write ? 32'd0 : asm_data;
              resp_misaligned <= q_mis;
              state           <= RESP;
            end
          end
        end
        RESP: begin
          resp_valid      <= 1'b0;
          resp_misaligned <= 1'b0;
          req_ready       <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: split-mode and legacy-mode instances
// share one wait-stated memory model; expectations come from a byte-level model.
module tb_mem_access_sequencer;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        wr;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          lat;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic        req_valid, req_write, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        va, vb;

  logic        a_req_ready, a_resp_valid, a_resp_mis, a_mem_valid, a_mem_write;
  logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_be;
  logic        b_req_ready, b_resp_valid, b_resp_mis, b_mem_valid, b_mem_write;
  logic [31:0] b_resp_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_be;

  logic        c_resp_valid, c_resp_mis, m_valid, m_write;
  logic [31:0] c_resp_rdata, m_addr, m_wdata;
  logic [3:0]  m_be;

  beat_t beat_q[$];
  resp_t resp_q[$];
  int    wait_q[$];
  logic [31:0] memimg [logic [31:0]];
  int    wait_max = 0;
  int    cyc = 0;
  int    accept_cyc = 0;
  int    errors = 0;
  int    checks = 0;
  int    wleft = 0;
  bit    busy = 1'b0;
  resp_t mon_e;
  beat_t mem_e;
  logic [31:0] mk;

  assign va = req_valid & ~mode;
  assign vb = req_valid & mode;
  assign c_resp_valid = mode ? b_resp_valid : a_resp_valid;
  assign c_resp_rdata = mode ? b_resp_rdata : a_resp_rdata;
  assign c_resp_mis   = mode ? b_resp_mis   : a_resp_mis;
  assign m_valid      = mode ? b_mem_valid  : a_mem_valid;
  assign m_write      = mode ? b_mem_write  : a_mem_write;
  assign m_addr       = mode ? b_mem_addr   : a_mem_addr;
  assign m_be         = mode ? b_mem_be     : a_mem_be;
  assign m_wdata      = mode ? b_mem_wdata  : a_mem_wdata;

  mem_access_sequencer #(.DATA_W(32), .ADDR_W(32), .ALLOW_SPLIT(1'b1)) dut_a (
    .clk(clk), .reset(reset), .req_valid(va), .req_ready(a_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_signed(req_signed), .req_wdata(req_wdata), .resp_valid(a_resp_valid),
    .resp_rdata(a_resp_rdata), .resp_misaligned(a_resp_mis), .mem_valid(a_mem_valid),
    .mem_ready(mem_ready), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
    .mem_be(a_mem_be), .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata));

  mem_access_sequencer #(.DATA_W(32), .ADDR_W(32), .ALLOW_SPLIT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .req_valid(vb), .req_ready(b_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_signed(req_signed), .req_wdata(req_wdata), .resp_valid(b_resp_valid),
    .resp_rdata(b_resp_rdata), .resp_misaligned(b_resp_mis), .mem_valid(b_mem_valid),
    .mem_ready(mem_ready), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .mem_be(b_mem_be), .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] read_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (memimg.exists(w)) return memimg[w];
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = read_word(a);
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  // Reference: the access touches bytes base..base+sb-1, little-endian
  task automatic push_model(input bit md, input bit w, input logic [31:0] a,
                            input logic [1:0] sz, input bit sg, input logic [31:0] wd);
    int          sb;
    int          nb;
    beat_t       bt [2];
    logic [31:0] base, ba, wa, v, w32;
    logic [63:0] dd;
    resp_t       r;
    sb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    base = md ? (a & ~32'(sb - 1)) : a;
    nb   = 0;
    v    = 32'h0;
    for (int i = 0; i < sb; i++) begin
      ba = base + 32'(i);
      wa = {ba[31:2], 2'b00};
      if (nb == 0 || bt[nb-1].addr != wa) begin
        nb++;
        bt[nb-1] = '{addr: wa, be: 4'b0000, wr: w, wdata: 32'h0};
      end
      bt[nb-1].be[ba[1:0]] = 1'b1;
      bt[nb-1].wdata[{ba[1:0], 3'b000} +: 8] = wd[8*i +: 8];
      v[8*i +: 8] = byte_at(ba);
    end
    for (int j = 0; j < nb; j++) beat_q.push_back(bt[j]);
    if (md && sb == 4) begin
      w32 = read_word(base);
      dd  = {w32, w32} >> (8 * int'(a[1:0]));
      v   = dd[31:0];
    end
    if (sg && sb < 4 && v[8*sb-1]) v = v | ~((32'd1 << (8 * sb)) - 32'd1);
    r.rdata = w ? 32'h0 : v;
    r.mis   = (a % 32'(sb)) != 0;
    r.lat   = -1;
    resp_q.push_back(r);
  endtask

  task automatic drive(input bit md, input bit w, input logic [31:0] a,
                       input logic [1:0] sz, input bit sg, input logic [31:0] wd);
    int   n;
    logic rdy;
    n = 0;
    @(negedge clk);
    mode = md; req_write = w; req_addr = a; req_size = sz; req_signed = sg; req_wdata = wd;
    req_valid = 1'b1;
    rdy = md ? b_req_ready : a_req_ready;
    while (rdy !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      rdy = md ? b_req_ready : a_req_ready;
    end
    if (rdy !== 1'b1) begin
      chk("req_accept", 32'(rdy), 32'd1);
      req_valid = 1'b0;
    end else begin
      accept_cyc = cyc;
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((resp_q.size() != 0 || a_req_ready !== 1'b1 || b_req_ready !== 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("idle_wait", 32'(resp_q.size()), 32'd0);
  endtask

  // Memory model with wait states; checks each beat as it is accepted
  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (!reset || !m_valid) begin
      busy = 1'b0;
    end else begin
      if (!busy) begin
        busy  = 1'b1;
        wleft = (wait_q.size() != 0) ? wait_q.pop_front() : int'($urandom_range(0, wait_max));
      end
      if (wleft == 0) begin
        mem_ready = 1'b1;
        mem_rdata = read_word(m_addr);
        busy      = 1'b0;
        if (beat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got addr %h be %b expected no beat", m_addr, m_be);
        end else begin
          mem_e = beat_q.pop_front();
          mk = {{8{mem_e.be[3]}}, {8{mem_e.be[2]}}, {8{mem_e.be[1]}}, {8{mem_e.be[0]}}};
          chk("beat_addr", m_addr, mem_e.addr);
          chk("beat_be", 32'(m_be), 32'(mem_e.be));
          chk("beat_write", 32'(m_write), 32'(mem_e.wr));
          if (mem_e.wr) chk("beat_wdata", m_wdata & mk, mem_e.wdata & mk);
        end
      end else begin
        wleft--;
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (reset && c_resp_valid) begin
      if (resp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 rdata %h expected no response", c_resp_rdata);
      end else begin
        mon_e = resp_q.pop_front();
        chk("resp_rdata", c_resp_rdata, mon_e.rdata);
        chk("resp_misaligned", 32'(c_resp_mis), 32'(mon_e.mis));
        if (mon_e.lat >= 0) chk("resp_latency", 32'(cyc - accept_cyc), 32'(mon_e.lat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sa, sw;
    logic [3:0]  sbe;
    logic [31:0] ra;
    reset = 1'b0; mode = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_size = '0; req_signed = 1'b0; req_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_req_ready", 32'(a_req_ready), 32'd1);
    chk("rst_resp_valid", 32'(a_resp_valid), 32'd0);
    chk("rst_resp_rdata", a_resp_rdata, 32'd0);
    chk("rst_resp_mis", 32'(a_resp_mis), 32'd0);
    chk("rst_mem_valid", 32'(a_mem_valid), 32'd0);
    chk("rst_mem_write", 32'(a_mem_write), 32'd0);
    chk("rst_mem_addr", a_mem_addr, 32'd0);
    chk("rst_mem_be", 32'(a_mem_be), 32'd0);
    chk("rst_mem_wdata", a_mem_wdata, 32'd0);
    chk("rst_b_req_ready", 32'(b_req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;

    // Aligned word load
    memimg[32'h100] = 32'hDEADBEEF;
    beat_q.push_back('{32'h100, 4'b1111, 1'b0, 32'h0});
    resp_q.push_back('{32'hDEADBEEF, 1'b0, 2});
    drive(1'b0, 1'b0, 32'h103 - 32'h3, 2'b10, 1'b0, 32'h0);
    wait_idle();

    // Byte loads, signed and unsigned
    memimg[32'h100] = 32'h80112233;
    beat_q.push_back('{32'h100, 4'b1000, 1'b0, 32'h0});
    resp_q.push_back('{32'hFFFFFF80, 1'b0, 2});
    drive(1'b0, 1'b0, 32'h103, 2'b00, 1'b1, 32'h0);
    wait_idle();
    beat_q.push_back('{32'h100, 4'b1000, 1'b0, 32'h0});
    resp_q.push_back('{32'h00000080, 1'b0, 2});
    drive(1'b0, 1'b0, 32'h103, 2'b00, 1'b0, 32'h0);
    wait_idle();

    // Split word load
    memimg[32'h100] = 32'h11223344;
    memimg[32'h104] = 32'h55667788;
    beat_q.push_back('{32'h100, 4'b1100, 1'b0, 32'h0});
    beat_q.push_back('{32'h104, 4'b0011, 1'b0, 32'h0});
    resp_q.push_back('{32'h77881122, 1'b1, 3});
    drive(1'b0, 1'b0, 32'h102, 2'b10, 1'b0, 32'h0);
    wait_idle();

    // Split halfword store
    beat_q.push_back('{32'h100, 4'b1000, 1'b1, 32'hCD000000});
    beat_q.push_back('{32'h104, 4'b0001, 1'b1, 32'h000000AB});
    resp_q.push_back('{32'h0, 1'b1, 3});
    drive(1'b0, 1'b1, 32'h103, 2'b01, 1'b0, 32'h0000ABCD);
    wait_idle();

    // Three wait cycles in BEAT0 with a competing request held
    memimg[32'h200] = 32'hCAFEF00D;
    wait_q.push_back(3);
    beat_q.push_back('{32'h200, 4'b1111, 1'b0, 32'h0});
    resp_q.push_back('{32'hCAFEF00D, 1'b0, 5});
    drive(1'b0, 1'b0, 32'h200, 2'b10, 1'b0, 32'h0);
    sa = a_mem_addr; sbe = a_mem_be; sw = a_mem_wdata;
    req_addr = 32'h300; req_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("wait_mem_valid", 32'(a_mem_valid), 32'd1);
      chk("wait_addr_stable", a_mem_addr, sa);
      chk("wait_be_stable", 32'(a_mem_be), 32'(sbe));
      chk("wait_wdata_stable", a_mem_wdata, sw);
      chk("wait_req_ready", 32'(a_req_ready), 32'd0);
    end
    req_valid = 1'b0;
    wait_idle();

    // Reset in BEAT1 of a split load drops the operation
    push_model(1'b0, 1'b0, 32'h302, 2'b10, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h302, 2'b10, 1'b0, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_mem_valid", 32'(a_mem_valid), 32'd0);
    chk("rst_mid_resp_valid", 32'(a_resp_valid), 32'd0);
    chk("rst_mid_req_ready", 32'(a_req_ready), 32'd1);
    beat_q.delete();
    resp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_resp", 32'(a_resp_valid), 32'd0);
    end
    chk("post_rst_req_ready", 32'(a_req_ready), 32'd1);

    // Legacy single-beat misaligned word load
    memimg[32'h100] = 32'h11223344;
    beat_q.push_back('{32'h100, 4'b1111, 1'b0, 32'h0});
    resp_q.push_back('{32'h44112233, 1'b1, 2});
    drive(1'b1, 1'b0, 32'h101, 2'b10, 1'b0, 32'h0);
    wait_idle();

    // Randomized traffic on both instances, including address wrap
    wait_max = 2;
    for (int md = 0; md < 2; md++) begin
      repeat (60) begin
        bit          w, sg;
        logic [1:0]  sz;
        logic [31:0] wd;
        ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                          : 32'h1000 + 32'($urandom_range(0, 63));
        sz = 2'($urandom_range(0, 3));
        w  = 1'($urandom_range(0, 1));
        sg = 1'($urandom_range(0, 1));
        wd = $urandom;
        push_model(md[0], w, ra, sz, sg, wd);
        drive(md[0], w, ra, sz, sg, wd);
      end
      wait_idle();
    end

    chk("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    chk("beat_queue_drained", 32'(beat_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
Multicycle load/store engine between the processor datapath and a ready/valid memory port. It takes one request (address, size, signedness, write data), drives one or two aligned memory beats with byte enables, then returns extended load data or a write-completion pulse. It generalises the single-cycle byte-enable, extend and align logic to parametrised bus width, wait-stated memory, and split misaligned accesses.

Parameters:
DATA_W, 32, memory bus width in bits; legal values 32 or 64; BYTES = DATA_W/8.
ADDR_W, 32, address width.
ALLOW_SPLIT, 1, 1: misaligned accesses split into two beats; 0: legacy ARMv4 single-beat handling.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
req_valid  in  1  datapath request valid.
req_ready  out  1  sequencer can accept a request.
req_write  in  1  1 = store, 0 = load.
req_addr  in  ADDR_W  byte address.
req_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
req_signed  in  1  sign-extend load result.
req_wdata  in  32  store data, right-justified.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  32  extended load data; 0 for stores.
resp_misaligned  out  1  addr not a multiple of the size; valid with resp_valid.
mem_valid  out  1  beat request.
mem_ready  in  1  beat accepted; read data valid in the same cycle.
mem_write  out  1  beat is a write.
mem_addr  out  ADDR_W  beat address, low log2(BYTES) bits zero.
mem_be  out  BYTES  byte-lane enables.
mem_wdata  out  DATA_W  lane-aligned write data.
mem_rdata  in  DATA_W  read data.

Behaviour:
- States: IDLE, BEAT0, BEAT1, RESP. Reset (asserted low) forces IDLE immediately (async). Reset values: req_ready=1; resp_valid, resp_rdata, resp_misaligned, mem_valid, mem_write, mem_addr, mem_be, mem_wdata all 0.
- IDLE: req_ready=1. Handshake on req_valid && req_ready latches every req_* field; next state is BEAT0. req_ready=0 in all other states. No resp backpressure.
- Definitions: sb = 1/2/4 bytes; off = addr mod BYTES; split = ALLOW_SPLIT && (off+sb > BYTES).
- BEAT0: mem_valid=1, mem_addr=addr with low bits cleared, mem_be = ((1<<sb)-1)<<off truncated to BYTES. mem_wdata = wdata rotated left by 8*off within a 2*DATA_W window, low half. On mem_ready, capture mem_rdata. Next state is BEAT1 if split, else RESP.
- BEAT1: mem_addr = beat0 addr + BYTES (wraps modulo 2^ADDR_W). mem_be = ((1<<sb)-1)>>(BYTES-off). mem_wdata = high half of the window. On mem_ready, capture mem_rdata and go to RESP.
- While mem_valid && !mem_ready, mem_addr, mem_be, mem_wdata and mem_write are held stable. There is no timeout.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. A new request can be accepted in the cycle after RESP.
- Load assembly: {beat1, beat0} >> 8*off. Take the low sb bytes, then zero- or sign-extend to 32 bits per req_signed (bit 8*sb-1).
- ALLOW_SPLIT=0 with a misaligned access:
  - Single beat at addr with the low log2(sb) bits cleared.
  - Word load: the aligned word rotated right by 8*addr[1:0].
  - Halfword/byte: extracted from the aligned-down address.
  - Stores write at the aligned-down address.
- resp_misaligned=1 whenever addr mod sb != 0, in both modes.
- Latency with zero-wait memory: acceptance edge → BEAT0 → RESP. resp_valid is 2 cycles after acceptance (3 if split). Each memory wait cycle adds 1.
- Reset during BEAT0, BEAT1 or RESP: the operation is dropped, no resp_valid is issued, and mem_valid falls asynchronously.

Test Plan:
1. DATA_W=32, load word 0x100 unsigned, mem_ready=1, mem_rdata=0xDEADBEEF → mem_addr=0x100, mem_be=1111, resp_valid 2 cycles after accept, resp_rdata=0xDEADBEEF, resp_misaligned=0.
2. Load byte 0x103, mem_rdata=0x80112233 → mem_be=1000. Signed: resp_rdata=0xFFFFFF80. Unsigned: 0x00000080.
3. Load word 0x102 split → beat0 0x100 be=1100 rdata=0x11223344; beat1 0x104 be=0011 rdata=0x55667788 → resp_rdata=0x77881122, resp_misaligned=1, resp 3 cycles after accept.
4. Store halfword 0x103, wdata=0x0000ABCD → beat0 0x100 be=1000, mem_wdata[31:24]=0xCD; beat1 0x104 be=0001, mem_wdata[7:0]=0xAB. resp_valid pulses, resp_rdata=0.
5. mem_ready held low 3 cycles in BEAT0 → mem_addr/be/wdata stable, req_ready=0, a second req_valid is not accepted. Then reset pulsed low in BEAT1 of a split load → mem_valid=0 immediately, no resp_valid, req_ready=1 after release.
6. ALLOW_SPLIT=0, load word 0x101, mem_rdata=0x11223344 → single beat 0x100, be=1111, resp_rdata=0x44112233, resp_misaligned=1.
